// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the time-multiplexed adder-tree reduction.
package adder_tree_pkg;

  localparam int DEFAULT_ADDER_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Number of additions performed at tree level lvl for num_inputs leaves.
  function automatic int unsigned pairs_at_level(input int unsigned num_inputs,
                                                 input int unsigned lvl);
    return num_inputs >> (lvl + 1);
  endfunction

endpackage

// File: rtl/adder_tree_branch.sv
// Single two-input unsigned adder node; the output carries one extra bit for the carry.
module adder_tree_branch
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
  parameter int EXTRA_BITS  = 1
) (
  input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] a,
  input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] b,
  output logic [ADDER_WIDTH+EXTRA_BITS:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_tree_sequencer.sv
// Sums NUM_INPUTS operands through one shared adder, reducing level by level in place
// inside an operand buffer; result leaves through a valid/ready output.
module adder_tree_sequencer
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
  parameter int NUM_INPUTS  = 8,
  parameter int CNT_WIDTH   = 16,
  localparam int LEVELS     = $clog2(NUM_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDER_WIDTH+LEVELS-1:0]     out_sum,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              done_count
);

  localparam int SUM_W = ADDER_WIDTH + LEVELS;

  state_e               state_q, state_d;
  logic [LEVELS-1:0]    lvl_q, lvl_d;
  logic [LEVELS-1:0]    pair_q, pair_d;
  logic [SUM_W-1:0]     opbuf_q [NUM_INPUTS];
  logic [SUM_W-1:0]     opbuf_d [NUM_INPUTS];
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;

  logic [LEVELS-1:0]    idx_a, idx_b;
  logic [SUM_W:0]       add_sum;
  logic                 add_carry_unused;
  logic                 last_pair, last_level;
  logic                 in_fire, out_fire;

  // pair_q < NUM_INPUTS/2, so the shift never loses a set bit.
  assign idx_a = pair_q << 1;
  assign idx_b = idx_a | LEVELS'(1);

  adder_tree_branch #(
    .ADDER_WIDTH (ADDER_WIDTH),
    .EXTRA_BITS  (LEVELS)
  ) u_adder (
    .a   (opbuf_q[idx_a]),
    .b   (opbuf_q[idx_b]),
    .sum (add_sum)
  );

  // LEVELS guard bits already hold the full sum; the carry is structurally zero.
  assign add_carry_unused = add_sum[SUM_W];

  assign last_pair  = (32'(pair_q) == pairs_at_level(NUM_INPUTS, 32'(lvl_q)) - 1);
  assign last_level = (32'(lvl_q) == 32'(LEVELS - 1));

  assign in_fire  = (state_q == IDLE) && in_valid && !flush;
  assign out_fire = (state_q == DONE) && out_ready && !flush;

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    pair_d     = pair_q;
    opbuf_d    = opbuf_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            opbuf_d[i] = {{LEVELS{1'b0}}, in_data[i*ADDER_WIDTH +: ADDER_WIDTH]};
          end
          lvl_d   = '0;
          pair_d  = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        // Writing slot p only overwrites a slot already consumed earlier this level.
        opbuf_d[pair_q] = add_sum[SUM_W-1:0];
        if (last_pair) begin
          pair_d = '0;
          lvl_d  = lvl_q + LEVELS'(1);
          if (last_level) state_d = DONE;
        end else begin
          pair_d = pair_q + LEVELS'(1);
        end
      end
      DONE: begin
        if (out_fire) begin
          if (done_cnt_q != '1) done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      pair_q     <= '0;
      done_cnt_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) opbuf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      pair_q     <= pair_d;
      done_cnt_q <= done_cnt_d;
      opbuf_q    <= opbuf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == REDUCE) || (state_q == DONE);
  assign out_sum    = opbuf_q[0];
  assign done_count = done_cnt_q;

endmodule
